// File: rtl/mgmt_tx_arbiter.sv
// mgmt_tx_arbiter: round-robin frame arbiter for the management PHY TX path.
// Grants whole frames, registers the granted byte stream, polices stalls/length.
module mgmt_tx_arbiter #(
  parameter int NUM_SRC       = 3,
  parameter int START_TIMEOUT = 64,
  parameter int MAX_FRAME     = 1522,
  parameter int GAP_CYCLES    = 2,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 link_up,
  input  logic                 mac_tx_ready,
  input  logic [NUM_SRC-1:0]   src_req,
  output logic [NUM_SRC-1:0]   src_tx_ready,
  input  logic [NUM_SRC-1:0]   src_start,
  input  logic [NUM_SRC-1:0]   src_data_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic                 tx_start,
  output logic                 tx_data_valid,
  output logic [7:0]           tx_data,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_overlength
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [10:0]   MAXF     = 11'(MAX_FRAME);
  localparam logic [10:0]   BC_SAT   = 11'h7ff;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    ACTIVE,
    GAP
  } state_t;

  state_t state, state_d;

  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [IW-1:0] pick, hi, lo;
  logic          pick_ok, hi_ok;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;
  logic [10:0]   byte_count;
  logic          seen_data, ovl_done;
  logic          g_req, g_start, g_valid;
  logic [7:0]    g_data;
  logic          do_grant, do_start;
  logic          fwd, tmo, ovl;

  assign busy   = (state != IDLE);
  assign rr_nxt = (grant_id == IW'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

  // Steer the granted source's strobes and byte onto local signals.
  always_comb begin
    g_req   = 1'b0;
    g_start = 1'b0;
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == IW'(i)) begin
        g_req   = src_req[i];
        g_start = src_start[i];
        g_valid = src_data_valid[i];
        g_data  = src_data[8*i +: 8];
      end
    end
  end

  // Round-robin pick: lowest requester at/after rr_ptr, else lowest overall.
  always_comb begin
    hi    = '0;
    lo    = '0;
    hi_ok = 1'b0;
    pick_ok = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        lo      = IW'(i);
        pick_ok = 1'b1;
        if (IW'(i) >= rr_ptr) begin
          hi    = IW'(i);
          hi_ok = 1'b1;
        end
      end
    end
    pick = hi_ok ? hi : lo;
  end

  // Only the granted source sees a go, and only while the MAC can take it.
  always_comb begin
    src_tx_ready = '0;
    if (state == WAIT_START && mac_tx_ready)
      src_tx_ready[grant_id] = 1'b1;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d  = state;
    do_grant = 1'b0;
    do_start = 1'b0;
    fwd      = 1'b0;
    tmo      = 1'b0;
    ovl      = 1'b0;
    unique case (state)
      IDLE: begin
        if (link_up && mac_tx_ready && pick_ok) begin
          do_grant = 1'b1;
          state_d  = WAIT_START;
        end
      end
      WAIT_START: begin
        if (g_start) begin
          do_start = 1'b1;
          fwd      = g_valid;
          state_d  = ACTIVE;
        end else if (!g_req) begin
          state_d = GAP;
        end else if (timer == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = GAP;
        end
      end
      ACTIVE: begin
        if (g_valid) begin
          fwd = (byte_count < MAXF);
          ovl = (byte_count >= MAXF) && !ovl_done;
        end else if (seen_data) begin
          state_d = GAP;
        end else if (timer == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  // Grant bookkeeping, timers, byte counting and the registered MAC outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start       <= 1'b0;
      tx_data_valid  <= 1'b0;
      tx_data        <= '0;
      err_timeout    <= 1'b0;
      err_overlength <= 1'b0;
      grant_id       <= '0;
      rr_ptr         <= '0;
      timer          <= '0;
      gap_cnt        <= '0;
      byte_count     <= '0;
      seen_data      <= 1'b0;
      ovl_done       <= 1'b0;
    end else begin
      tx_start       <= do_start;
      tx_data_valid  <= fwd;
      err_timeout    <= tmo;
      err_overlength <= ovl;
      if (fwd)
        tx_data <= g_data;
      if (do_grant)
        grant_id <= pick;
      if (state != GAP && state_d == GAP)
        rr_ptr <= rr_nxt;
      if (do_grant || do_start)
        timer <= '0;
      else if (state == WAIT_START || (state == ACTIVE && !seen_data))
        timer <= timer + 1'b1;
      if (do_start) begin
        byte_count <= {10'd0, g_valid};
        seen_data  <= g_valid;
        ovl_done   <= 1'b0;
      end else if (state == ACTIVE && g_valid) begin
        seen_data <= 1'b1;
        if (byte_count != BC_SAT)
          byte_count <= byte_count + 1'b1;
        if (ovl)
          ovl_done <= 1'b1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_mgmt_tx_arbiter.sv
// tb_mgmt_tx_arbiter: directed frame table plus hand sequences for
// link gating and mid-frame reset of mgmt_tx_arbiter.
module tb_mgmt_tx_arbiter;

  localparam int NS   = 3;
  localparam int TMO  = 64;
  localparam int MAXF = 1522;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up;
  logic        mac_tx_ready;
  logic [2:0]  src_req;
  logic [2:0]  src_tx_ready;
  logic [2:0]  src_start;
  logic [2:0]  src_data_valid;
  logic [23:0] src_data;
  logic        tx_start;
  logic        tx_data_valid;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;
  logic        err_overlength;

  always #5 clk = ~clk;

  mgmt_tx_arbiter #(
    .NUM_SRC(NS), .START_TIMEOUT(TMO),
    .MAX_FRAME(MAXF), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .link_up(link_up), .mac_tx_ready(mac_tx_ready),
    .src_req(src_req), .src_tx_ready(src_tx_ready),
    .src_start(src_start), .src_data_valid(src_data_valid),
    .src_data(src_data),
    .tx_start(tx_start), .tx_data_valid(tx_data_valid),
    .tx_data(tx_data), .grant_id(grant_id), .busy(busy),
    .err_timeout(err_timeout), .err_overlength(err_overlength)
  );

  typedef struct {
    logic [2:0] mask;
    int len;
    int dly;
    bit same;
    bit noise;
    int exp_g;
    int exp_fwd;
    int exp_ovl;
    int exp_tmo;
  } vec_t;

  vec_t rows [12];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_v = -1000;
  int min_gap = 1000;
  int start_cnt = 0;
  int tmo_cnt = 0;
  int ovl_cnt = 0;
  logic [7:0] mon_q [$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_data_valid) begin
      mon_q.push_back(tx_data);
      last_v <= cyc;
    end
    if (tx_start) begin
      start_cnt <= start_cnt + 1;
      if (cyc - last_v - 1 < min_gap)
        min_gap <= cyc - last_v - 1;
    end
    if (err_timeout)
      tmo_cnt <= tmo_cnt + 1;
    if (err_overlength)
      ovl_cnt <= ovl_cnt + 1;
  end

  function automatic logic [7:0] pat(input int g, input int k);
    return 8'((g * 37 + k * 7 + 3) & 255);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] gi, input int k);
    logic [2:0]  gm;
    logic [23:0] dm;
    logic [7:0]  b;
    gm = 3'b001 << gi;
    dm = {{8{gm[2]}}, {8{gm[1]}}, {8{gm[0]}}};
    b  = pat(int'(gi), k);
    src_data_valid = src_data_valid | gm;
    src_data = (src_data & ~dm) | ({3{b}} & dm);
  endtask

  task automatic noise(input logic [1:0] gi);
    logic [2:0]  m;
    logic [23:0] dm;
    m  = ~(3'b001 << gi);
    dm = {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    src_start      = (src_start & ~m) | (3'($urandom) & m);
    src_data_valid = (src_data_valid & ~m) | (3'($urandom) & m);
    src_data       = (src_data & ~dm) | (24'($urandom) & dm);
  endtask

  task automatic wait_ready(output bit ok);
    int c;
    c  = 0;
    ok = 1'b0;
    while (!ok && c < 100) begin
      @(posedge clk); #1;
      c++;
      ok = |src_tx_ready;
    end
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic run_row(input int r);
    vec_t v;
    logic [1:0] gi;
    int c, k, base, s0, t0, o0, nbad, got;
    bit ok;
    string p;
    v    = rows[r];
    p    = $sformatf("row%0d", r);
    base = mon_q.size();
    s0   = start_cnt;
    t0   = tmo_cnt;
    o0   = ovl_cnt;
    src_req = v.mask;
    wait_ready(ok);
    if (!ok) begin
      check({p, " ready_timeout"}, 0, 1);
      src_req = '0;
      wait_idle(c);
      return;
    end
    gi = grant_id;
    check({p, " grant_id"}, int'(gi), v.exp_g);
    check({p, " tx_ready_onehot"}, int'(src_tx_ready), 1 << v.exp_g);
    repeat (v.dly) begin
      @(posedge clk); #1;
    end
    k = 0;
    if (v.len >= 0) begin
      src_start = 3'b001 << gi;
      if (v.same && v.len > 0) begin
        drive(gi, 0);
        k = 1;
      end
      if (v.noise) noise(gi);
      @(posedge clk); #1;
      src_start = src_start & ~(3'b001 << gi);
      check({p, " tx_start"}, int'(tx_start), 1);
      while (k < v.len) begin
        src_data_valid = '0;
        drive(gi, k);
        if (v.noise) noise(gi);
        k++;
        @(posedge clk); #1;
      end
      src_data_valid = '0;
      src_start = '0;
      if (v.len > 0) begin
        src_req = '0;
        wait_idle(c);
        check({p, " busy_low_latency"}, c, GAP + 1);
      end
    end
    if (v.len <= 0) begin
      c = 0;
      while (!err_timeout && c < 200) begin
        @(posedge clk); #1;
        c++;
      end
      check({p, " timeout_latency"}, c, TMO);
      src_req = '0;
    end
    wait_idle(c);
    check({p, " idle"}, int'(busy), 0);
    got = mon_q.size() - base;
    check({p, " byte_count"}, got, v.exp_fwd);
    nbad = 0;
    for (int i = 0; i < v.exp_fwd && i < got; i++)
      if (mon_q[base + i] != pat(v.exp_g, i))
        nbad++;
    check({p, " data_mismatches"}, nbad, 0);
    check({p, " start_pulses"}, start_cnt - s0, (v.len >= 0) ? 1 : 0);
    check({p, " timeout_pulses"}, tmo_cnt - t0, v.exp_tmo);
    check({p, " overlength_pulses"}, ovl_cnt - o0, v.exp_ovl);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t0;
    bit ok;
    logic [17:0] outs;

    //         mask    len  dly sm nz  g  fwd  ovl tmo
    rows[0]  = '{3'b010,   64, 2, 0, 0, 1,   64, 0, 0};
    rows[1]  = '{3'b111,   60, 0, 0, 0, 2,   60, 0, 0};
    rows[2]  = '{3'b111,   60, 1, 1, 0, 0,   60, 0, 0};
    rows[3]  = '{3'b111,   60, 0, 1, 0, 1,   60, 0, 0};
    rows[4]  = '{3'b111,   60, 3, 0, 0, 2,   60, 0, 0};
    rows[5]  = '{3'b111,   60, 0, 0, 0, 0,   60, 0, 0};
    rows[6]  = '{3'b111,   60, 0, 1, 0, 1,   60, 0, 0};
    rows[7]  = '{3'b101,   -1, 0, 0, 0, 2,    0, 0, 1};
    rows[8]  = '{3'b101,   10, 0, 0, 0, 0,   10, 0, 0};
    rows[9]  = '{3'b010,    0, 0, 0, 0, 1,    0, 0, 1};
    rows[10] = '{3'b010, 1600, 0, 1, 0, 1, 1522, 1, 0};
    rows[11] = '{3'b011,   40, 0, 0, 1, 0,   40, 0, 0};

    rst_n = 1'b0;
    link_up = 1'b1;
    mac_tx_ready = 1'b1;
    src_req = '0;
    src_start = '0;
    src_data_valid = '0;
    src_data = '0;
    repeat (3) @(posedge clk);
    #1;
    outs = {tx_start, tx_data_valid, tx_data, grant_id, busy,
            err_timeout, err_overlength, src_tx_ready};
    check("reset_outputs", int'(outs), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", int'(busy), 0);

    for (int r = 0; r < 12; r++)
      run_row(r);

    link_up = 1'b0;
    src_req = 3'b111;
    c = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || src_tx_ready != '0) c++;
    end
    check("link_down_no_grant", c, 0);
    link_up = 1'b1;
    mac_tx_ready = 1'b0;
    c = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || src_tx_ready != '0) c++;
    end
    check("mac_not_ready_no_grant", c, 0);
    src_req = '0;
    mac_tx_ready = 1'b1;
    @(posedge clk); #1;

    src_req = 3'b100;
    wait_ready(ok);
    check("rst_seq grant", ok ? int'(grant_id) : -1, 2);
    src_start = 3'b100;
    drive(2'd2, 0);
    @(posedge clk); #1;
    src_start = '0;
    drive(2'd2, 1);
    @(posedge clk); #1;
    check("rst_seq midframe_valid", int'(tx_data_valid), 1);
    rst_n = 1'b0;
    #1;
    outs = {tx_start, tx_data_valid, tx_data, grant_id, busy,
            err_timeout, err_overlength, src_tx_ready};
    check("rst_seq async_outputs", int'(outs), 0);
    src_req = '0;
    src_data_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    src_req = 3'b111;
    wait_ready(ok);
    check("rst_seq regrant_id", ok ? int'(grant_id) : -1, 0);
    check("rst_seq regrant_ready", int'(src_tx_ready), 1);
    t0 = tmo_cnt;
    src_req = '0;
    wait_idle(c);
    check("req_drop idle", int'(busy), 0);
    check("req_drop no_timeout", tmo_cnt - t0, 0);

    check("min_gap_ok", int'(min_gap >= GAP), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
